// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and index-to-onehot helper for the FIFO
// write-side arbitration logic.
package fifo_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic logic [MAX_REQ-1:0] to_onehot(input int idx);
        to_onehot = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: picks the first valid requester after the last-grant pointer,
// searching cyclically, and returns it as both one-hot and index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    import fifo_pkg::*;

    logic [IW-1:0] j;

    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!any && valid[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
        onehot = any ? N'(to_onehot(int'(idx))) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the FIFO write port among
// NUM_REQ requesters, with full back-pressure.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy
);
    import fifo_pkg::*;

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    state_t             state, state_d;
    logic [NUM_REQ-1:0] grant_d, sel_oh;
    logic [IW-1:0]      ptr, ptr_d, sel_idx;
    logic [CW-1:0]      count, count_d;
    logic               sel_any, g_valid, xfer;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .valid  (req_valid),
        .ptr    (ptr),
        .onehot (sel_oh),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    // grant is zero outside BURST, so every output below idles at zero
    assign busy       = (state == BURST);
    assign g_valid    = |(req_valid & grant);
    assign xfer       = busy & g_valid & ~fifo_full;
    assign fifo_wr_en = xfer;
    assign req_ready  = xfer ? grant : '0;

    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) fifo_data = req_data[i*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d = state;
        grant_d = grant;
        ptr_d   = ptr;
        count_d = count;
        if (state == IDLE) begin
            if (sel_any) begin
                state_d = BURST;
                grant_d = sel_oh;
                ptr_d   = sel_idx;
                count_d = '0;
            end
        end else if (!g_valid) begin
            state_d = IDLE;
            grant_d = '0;
        end else if (xfer) begin
            // the final beat of a burst leaves, so count never reaches MAX_BURST
            state_d = (count == CW'(MAX_BURST - 1)) ? IDLE : BURST;
            grant_d = (count == CW'(MAX_BURST - 1)) ? '0 : grant;
            count_d = (count == CW'(MAX_BURST - 1)) ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= IW'(NUM_REQ - 1);
            count <= '0;
        end else begin
            state <= state_d;
            grant <= grant_d;
            ptr   <= ptr_d;
            count <= count_d;
        end
    end

endmodule
